// File: rtl/axon_fanout_if.sv
// Spike-event handshake and synapse/dendrite beat bus between the event source and axon_fanout.
interface axon_fanout_if #(
    parameter int NNW     = 12,
    parameter int WD      = 6,
    parameter int LAN_num = 2
) ();
    logic               spk_axon_vld;
    logic               spk_axon_rdy;
    logic [NNW-1:0]     spk_axon_vm_base;
    logic [NNW-1:0]     spk_axon_len;
    logic [WD-1:0]      spk_axon_wgt_base;
    logic [LAN_num-1:0] spk_axon_lans;

    logic [NNW-1:0]     axon_sd_vm_addr;
    logic [WD-1:0]      axon_sd_wgt_addr;
    logic [LAN_num-1:0] axon_sd_lans;
    logic               axon_sd_vld;

    // Event producer / beat consumer side
    modport master (
        output spk_axon_vld, spk_axon_vm_base, spk_axon_len, spk_axon_wgt_base, spk_axon_lans,
        input  spk_axon_rdy,
        input  axon_sd_vm_addr, axon_sd_wgt_addr, axon_sd_lans, axon_sd_vld
    );

    // Fan-out sequencer side
    modport slave (
        input  spk_axon_vld, spk_axon_vm_base, spk_axon_len, spk_axon_wgt_base, spk_axon_lans,
        output spk_axon_rdy,
        output axon_sd_vm_addr, axon_sd_wgt_addr, axon_sd_lans, axon_sd_vld
    );
endinterface

// File: rtl/axon_fanout.sv
// Expands one spike event into a one-beat-per-cycle stream of (vm, wgt, lans) beats toward the SD stage,
// inserting a bubble when consecutive beats would hit the same Vm address and yielding to config on hold.
module axon_fanout #(
    parameter int NNW     = 12,
    parameter int WD      = 6,
    parameter int LAN_num = 2,
    parameter int ECW     = 16
) (
    input  logic            clk_AXON,
    input  logic            rst,
    axon_fanout_if.slave    bus,
    input  logic            axon_hold,
    input  logic            config_axon_start,
    output logic            axon_busy,
    output logic [ECW-1:0]  axon_evt_cnt
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [NNW-1:0]     base_q, base_d;
    logic [WD-1:0]      wbase_q, wbase_d;
    logic [LAN_num-1:0] lans_q, lans_d;
    logic [NNW-1:0]     len_q, len_d;
    logic [NNW-1:0]     idx_q, idx_d;

    logic [NNW-1:0]     vm_q, vm_d;
    logic [WD-1:0]      wgt_q, wgt_d;
    logic [LAN_num-1:0] lo_q, lo_d;
    logic               vld_q, vld_d;
    logic [ECW-1:0]     cnt_q, cnt_d;

    logic [NNW-1:0]     cand_vm;
    logic [WD-1:0]      cand_wgt;
    logic               hazard;
    logic               issue;
    logic               last_beat;
    logic               rdy;
    logic               accept_nz;

    // Both address runs wrap silently at their own widths
    assign cand_vm   = base_q + idx_q;
    assign cand_wgt  = wbase_q + idx_q[WD-1:0];
    // SD write-back takes one cycle, so a repeat of the previous Vm address must wait
    assign hazard    = vld_q && (vm_q == cand_vm);
    assign issue     = (state_q == RUN) && !axon_hold && !hazard;
    assign last_beat = issue && (idx_q == (len_q - NNW'(1)));
    assign rdy       = (state_q == IDLE) || last_beat;
    assign accept_nz = bus.spk_axon_vld && rdy && (bus.spk_axon_len != '0);

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        wbase_d = wbase_q;
        lans_d  = lans_q;
        len_d   = len_q;
        idx_d   = idx_q;
        vm_d    = vm_q;
        wgt_d   = wgt_q;
        lo_d    = lo_q;
        vld_d   = 1'b0;
        cnt_d   = cnt_q;

        if (issue) begin
            vm_d  = cand_vm;
            wgt_d = cand_wgt;
            lo_d  = lans_q;
            vld_d = 1'b1;
            idx_d = idx_q + NNW'(1);
        end

        if (last_beat) begin
            state_d = IDLE;
        end

        // A handshake on the last beat overrides the return to IDLE for back-to-back events
        if (accept_nz) begin
            base_d  = bus.spk_axon_vm_base;
            wbase_d = bus.spk_axon_wgt_base;
            lans_d  = bus.spk_axon_lans;
            len_d   = bus.spk_axon_len;
            idx_d   = '0;
            state_d = RUN;
        end

        if (config_axon_start) begin
            cnt_d = '0;
        end
        if (accept_nz) begin
            cnt_d = cnt_d + ECW'(1);
        end
    end

    always_ff @(posedge clk_AXON) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            wbase_q <= '0;
            lans_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            vm_q    <= '0;
            wgt_q   <= '0;
            lo_q    <= '0;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            wbase_q <= wbase_d;
            lans_q  <= lans_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            vm_q    <= vm_d;
            wgt_q   <= wgt_d;
            lo_q    <= lo_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.spk_axon_rdy     = rdy;
    assign bus.axon_sd_vm_addr  = vm_q;
    assign bus.axon_sd_wgt_addr = wgt_q;
    assign bus.axon_sd_lans     = lo_q;
    assign bus.axon_sd_vld      = vld_q;
    assign axon_busy            = (state_q == RUN) || vld_q;
    assign axon_evt_cnt         = cnt_q;
endmodule

// File: tb/tb_axon_fanout.sv
// Directed bench for axon_fanout: table of single events plus hand-written hazard, hold, len=0/start and reset sequences.
module tb_axon_fanout;
    logic        clk_AXON;
    logic        rst;
    logic        axon_hold;
    logic        config_axon_start;
    logic        axon_busy;
    logic [15:0] axon_evt_cnt;

    axon_fanout_if #(.NNW(12), .WD(6), .LAN_num(2)) bus ();

    axon_fanout #(.NNW(12), .WD(6), .LAN_num(2), .ECW(16)) dut (
        .clk_AXON          (clk_AXON),
        .rst               (rst),
        .bus               (bus),
        .axon_hold         (axon_hold),
        .config_axon_start (config_axon_start),
        .axon_busy         (axon_busy),
        .axon_evt_cnt      (axon_evt_cnt)
    );

    initial clk_AXON = 1'b0;
    always #5 clk_AXON = ~clk_AXON;

    typedef struct packed {
        logic [11:0]       base;
        logic [11:0]       len;
        logic [5:0]        wbase;
        logic [1:0]        lans;
        logic [3:0][11:0]  exp_vm;
        logic [3:0][5:0]   exp_wgt;
    } vec_t;

    vec_t        tbl [4];
    int          checks;
    int          errors;
    logic [15:0] exp_cnt;
    logic        tr_vld [1:9];
    logic [11:0] tr_vm  [1:9];
    logic        tr_rdy [1:9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic drive_evt(input logic [11:0] b, input logic [11:0] l, input logic [5:0] w, input logic [1:0] ln);
        bus.spk_axon_vld      = 1'b1;
        bus.spk_axon_vm_base  = b;
        bus.spk_axon_len      = l;
        bus.spk_axon_wgt_base = w;
        bus.spk_axon_lans     = ln;
    endtask

    // Event A accepted from IDLE, B offered right after; records 7 cycles of bus activity
    task automatic run_pair(input logic [11:0] a_base, input logic [11:0] a_len,
                            input logic [11:0] b_base, input logic [11:0] b_len);
        logic b_pending;
        @(negedge clk_AXON);
        drive_evt(a_base, a_len, 6'd0, 2'b11);
        @(posedge clk_AXON);
        exp_cnt   = exp_cnt + 16'd1;
        b_pending = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk_AXON);
            if (b_pending) drive_evt(b_base, b_len, 6'd0, 2'b11);
            else           bus.spk_axon_vld = 1'b0;
            #1;
            tr_vld[i] = bus.axon_sd_vld;
            tr_vm[i]  = bus.axon_sd_vm_addr;
            tr_rdy[i] = bus.spk_axon_rdy;
            if (b_pending && bus.spk_axon_rdy) begin
                b_pending = 1'b0;
                exp_cnt   = exp_cnt + 16'd1;
            end
        end
        @(negedge clk_AXON);
        bus.spk_axon_vld = 1'b0;
    endtask

    initial begin
        logic        ev [1:9];
        logic [11:0] evm [1:9];

        tbl[0] = '{base: 12'd10,   len: 12'd3, wbase: 6'd5,  lans: 2'b01,
                   exp_vm: {12'd0, 12'd12, 12'd11, 12'd10},     exp_wgt: {6'd0, 6'd7, 6'd6, 6'd5}};
        tbl[1] = '{base: 12'd4094, len: 12'd4, wbase: 6'd62, lans: 2'b10,
                   exp_vm: {12'd1, 12'd0, 12'd4095, 12'd4094},  exp_wgt: {6'd1, 6'd0, 6'd63, 6'd62}};
        tbl[2] = '{base: 12'd100,  len: 12'd1, wbase: 6'd0,  lans: 2'b11,
                   exp_vm: {12'd0, 12'd0, 12'd0, 12'd100},      exp_wgt: {6'd0, 6'd0, 6'd0, 6'd0}};
        tbl[3] = '{base: 12'd7,    len: 12'd2, wbase: 6'd63, lans: 2'b00,
                   exp_vm: {12'd0, 12'd0, 12'd8, 12'd7},        exp_wgt: {6'd0, 6'd0, 6'd0, 6'd63}};

        checks = 0;
        errors = 0;
        exp_cnt = 16'd0;
        rst = 1'b1;
        axon_hold = 1'b0;
        config_axon_start = 1'b0;
        bus.spk_axon_vld = 1'b0;
        bus.spk_axon_vm_base = '0;
        bus.spk_axon_len = '0;
        bus.spk_axon_wgt_base = '0;
        bus.spk_axon_lans = '0;
        repeat (3) @(posedge clk_AXON);
        @(negedge clk_AXON);
        rst = 1'b0;
        #1;
        check("reset_vld",  bus.axon_sd_vld, 0);
        check("reset_vm",   bus.axon_sd_vm_addr, 0);
        check("reset_wgt",  bus.axon_sd_wgt_addr, 0);
        check("reset_lans", bus.axon_sd_lans, 0);
        check("reset_cnt",  axon_evt_cnt, 0);
        check("reset_busy", axon_busy, 0);
        check("reset_rdy",  bus.spk_axon_rdy, 1);

        // Single events from the table
        for (int t = 0; t < 4; t++) begin
            @(negedge clk_AXON);
            drive_evt(tbl[t].base, tbl[t].len, tbl[t].wbase, tbl[t].lans);
            #1;
            check($sformatf("t%0d_rdy_idle", t), bus.spk_axon_rdy, 1);
            @(posedge clk_AXON);
            exp_cnt = exp_cnt + 16'd1;
            @(negedge clk_AXON);
            bus.spk_axon_vld = 1'b0;
            #1;
            check($sformatf("t%0d_vld_c1", t), bus.axon_sd_vld, 0);
            for (int k = 0; k < int'(tbl[t].len); k++) begin
                @(negedge clk_AXON);
                #1;
                check($sformatf("t%0d_b%0d_vld", t, k),  bus.axon_sd_vld, 1);
                check($sformatf("t%0d_b%0d_vm", t, k),   bus.axon_sd_vm_addr, tbl[t].exp_vm[k]);
                check($sformatf("t%0d_b%0d_wgt", t, k),  bus.axon_sd_wgt_addr, tbl[t].exp_wgt[k]);
                check($sformatf("t%0d_b%0d_lans", t, k), bus.axon_sd_lans, tbl[t].lans);
            end
            @(negedge clk_AXON);
            #1;
            check($sformatf("t%0d_vld_end", t),  bus.axon_sd_vld, 0);
            check($sformatf("t%0d_busy_end", t), axon_busy, 0);
            check($sformatf("t%0d_cnt", t),      axon_evt_cnt, exp_cnt);
        end

        // Hazard: A(base 0,len 2) then B(base 1,len 1) -> 0,1,bubble,1
        run_pair(12'd0, 12'd2, 12'd1, 12'd1);
        ev  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        evm = '{12'd0, 12'd0, 12'd1, 12'd0, 12'd1, 12'd0, 12'd0, 12'd0, 12'd0};
        for (int i = 1; i <= 6; i++) begin
            check($sformatf("haz_c%0d_vld", i), tr_vld[i], ev[i]);
            if (ev[i]) check($sformatf("haz_c%0d_vm", i), tr_vm[i], evm[i]);
        end
        check("haz_rdy_c1", tr_rdy[1], 0);
        check("haz_rdy_last", tr_rdy[2], 1);
        check("haz_rdy_bubble", tr_rdy[3], 0);
        check("haz_cnt", axon_evt_cnt, exp_cnt);

        // Control: B base 5 follows with no gap
        run_pair(12'd0, 12'd2, 12'd5, 12'd1);
        ev  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        evm = '{12'd0, 12'd0, 12'd1, 12'd5, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0};
        for (int i = 1; i <= 6; i++) begin
            check($sformatf("ctl_c%0d_vld", i), tr_vld[i], ev[i]);
            if (ev[i]) check($sformatf("ctl_c%0d_vm", i), tr_vm[i], evm[i]);
        end
        check("ctl_rdy_c1", tr_rdy[1], 0);
        check("ctl_rdy_last", tr_rdy[2], 1);
        check("ctl_cnt", axon_evt_cnt, exp_cnt);

        // Hold: base 20 len 4, hold high for 3 cycles starting when beat 21 is on the bus
        @(negedge clk_AXON);
        drive_evt(12'd20, 12'd4, 6'd0, 2'b01);
        @(posedge clk_AXON);
        exp_cnt = exp_cnt + 16'd1;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk_AXON);
            bus.spk_axon_vld = 1'b0;
            axon_hold = (i >= 3 && i <= 5);
            #1;
            tr_vld[i] = bus.axon_sd_vld;
            tr_vm[i]  = bus.axon_sd_vm_addr;
            tr_rdy[i] = bus.spk_axon_rdy;
        end
        axon_hold = 1'b0;
        ev  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        evm = '{12'd0, 12'd20, 12'd21, 12'd0, 12'd0, 12'd0, 12'd22, 12'd23, 12'd0};
        for (int i = 1; i <= 9; i++) begin
            check($sformatf("hold_c%0d_vld", i), tr_vld[i], ev[i]);
            if (ev[i]) check($sformatf("hold_c%0d_vm", i), tr_vm[i], evm[i]);
        end
        for (int i = 3; i <= 5; i++) check($sformatf("hold_c%0d_rdy", i), tr_rdy[i], 0);
        check("hold_cnt", axon_evt_cnt, exp_cnt);

        // len=0 is accepted and dropped
        @(negedge clk_AXON);
        drive_evt(12'd300, 12'd0, 6'd3, 2'b11);
        #1;
        check("len0_rdy", bus.spk_axon_rdy, 1);
        @(posedge clk_AXON);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk_AXON);
            bus.spk_axon_vld = 1'b0;
            #1;
            check($sformatf("len0_c%0d_vld", i), bus.axon_sd_vld, 0);
            check($sformatf("len0_c%0d_rdy", i), bus.spk_axon_rdy, 1);
            check($sformatf("len0_c%0d_busy", i), axon_busy, 0);
        end
        check("len0_cnt", axon_evt_cnt, exp_cnt);

        // start coincident with len=1 handshake: clear then count
        @(negedge clk_AXON);
        drive_evt(12'd50, 12'd1, 6'd9, 2'b10);
        config_axon_start = 1'b1;
        @(posedge clk_AXON);
        @(negedge clk_AXON);
        bus.spk_axon_vld = 1'b0;
        config_axon_start = 1'b0;
        #1;
        check("start_cnt", axon_evt_cnt, 1);
        @(negedge clk_AXON);
        #1;
        check("start_beat_vld", bus.axon_sd_vld, 1);
        check("start_beat_vm", bus.axon_sd_vm_addr, 50);
        check("start_beat_wgt", bus.axon_sd_wgt_addr, 9);

        // Reset during beat 2 of a len=8 event
        @(negedge clk_AXON);
        drive_evt(12'd200, 12'd8, 6'd1, 2'b01);
        @(posedge clk_AXON);
        @(negedge clk_AXON);
        bus.spk_axon_vld = 1'b0;
        @(negedge clk_AXON);
        #1;
        check("rst_b1_vm", bus.axon_sd_vm_addr, 200);
        @(negedge clk_AXON);
        #1;
        check("rst_b2_vm", bus.axon_sd_vm_addr, 201);
        rst = 1'b1;
        @(negedge clk_AXON);
        rst = 1'b0;
        #1;
        check("rst_mid_vld",  bus.axon_sd_vld, 0);
        check("rst_mid_vm",   bus.axon_sd_vm_addr, 0);
        check("rst_mid_wgt",  bus.axon_sd_wgt_addr, 0);
        check("rst_mid_lans", bus.axon_sd_lans, 0);
        check("rst_mid_cnt",  axon_evt_cnt, 0);
        check("rst_mid_busy", axon_busy, 0);
        check("rst_mid_rdy",  bus.spk_axon_rdy, 1);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk_AXON);
            #1;
            check($sformatf("rst_post_c%0d_vld", i), bus.axon_sd_vld, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
